// File: rtl/h_bridge_driver_pkg.sv
// Shared types for the H-bridge gate driver: bridge modes,
// gate bundle and the mode-to-gate decode.
package h_bridge_driver_pkg;

  typedef enum logic [2:0] {
    BR_OFF   = 3'd0,
    BR_FWD   = 3'd1,
    BR_REV   = 3'd2,
    BR_BRAKE = 3'd3,
    BR_DEAD  = 3'd4
  } bridge_mode_t;

  localparam int DEFAULT_DEAD_TIME = 4;

  typedef struct packed {
    logic a_hi;
    logic a_lo;
    logic b_hi;
    logic b_lo;
  } gates_t;

  // Each leg only ever has one switch on, whatever the mode.
  function automatic gates_t decode(bridge_mode_t m, logic p);
    gates_t g;
    g = '0;
    case (m)
      BR_FWD: begin
        g.a_hi = p;
        g.b_lo = 1'b1;
      end
      BR_REV: begin
        g.b_hi = p;
        g.a_lo = 1'b1;
      end
      BR_BRAKE: begin
        g.a_lo = 1'b1;
        g.b_lo = 1'b1;
      end
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/dead_time_timer.sv
// Dead-time down counter: loads max(value,1), counts down to 1
// and holds there; expired flags the final dead cycle.
module dead_time_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         expired_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = (value_i == '0) ? ONE : value_i;
    end else if (dec_i && count_q > ONE) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == ONE);

endmodule

// File: rtl/h_bridge_driver.sv
// H-bridge gate driver: mode FSM with dead time between active
// modes, sticky fault latch and registered shoot-through-free gates.
module h_bridge_driver
  import h_bridge_driver_pkg::*;
#(
  parameter int DEAD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  pwm_in,
  input  logic                  dir,
  input  logic                  brake,
  input  logic                  fault,
  input  logic [DEAD_WIDTH-1:0] dead_time,
  output logic                  a_hi,
  output logic                  a_lo,
  output logic                  b_hi,
  output logic                  b_lo,
  output logic [2:0]            mode,
  output logic                  dead_active,
  output logic                  fault_latched
);

  bridge_mode_t state_q;
  bridge_mode_t req_d;
  gates_t       gates_q;
  logic         pwm_q;
  logic         fault_q;
  logic         active_q;
  logic         load_d;
  logic         clr_d;
  logic         dec_d;
  logic         expired;

  assign active_q = (state_q == BR_FWD) ||
                    (state_q == BR_REV) ||
                    (state_q == BR_BRAKE);

  always_comb begin
    req_d = BR_FWD;
    if (fault_q || fault || !enable) begin
      req_d = BR_OFF;
    end else if (brake) begin
      req_d = BR_BRAKE;
    end else if (dir) begin
      req_d = BR_REV;
    end
  end

  assign clr_d  = (req_d == BR_OFF);
  assign load_d = active_q && !clr_d && (req_d != state_q);
  assign dec_d  = (state_q == BR_DEAD);

  dead_time_timer #(
    .W (DEAD_WIDTH)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (clr_d),
    .load_i    (load_d),
    .value_i   (dead_time),
    .dec_i     (dec_d),
    .expired_o (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BR_OFF;
      gates_q <= '0;
      pwm_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pwm_q   <= pwm_in;
      gates_q <= decode(state_q, pwm_q);
      fault_q <= fault | (fault_q & enable);
      unique case (state_q)
        BR_OFF: state_q <= req_d;
        BR_FWD, BR_REV, BR_BRAKE: begin
          if (req_d == BR_OFF) begin
            state_q <= BR_OFF;
          end else if (req_d != state_q) begin
            state_q <= BR_DEAD;
          end
        end
        BR_DEAD: begin
          // Exit target is whatever is requested on the last dead cycle.
          if (req_d == BR_OFF || expired) begin
            state_q <= req_d;
          end
        end
        default: state_q <= BR_OFF;
      endcase
    end
  end

  assign a_hi          = gates_q.a_hi;
  assign a_lo          = gates_q.a_lo;
  assign b_hi          = gates_q.b_hi;
  assign b_lo          = gates_q.b_lo;
  assign mode          = state_q;
  assign dead_active   = (state_q == BR_DEAD);
  assign fault_latched = fault_q;

endmodule
